// File: rtl/angle_selector_if.sv
// Angle request channel between the angle selector and the weight block.
// The selector drives the angle and its valid/busy flags; the weight block
// answers with ready and a single-cycle completion pulse.
interface angle_selector_if;
  logic signed [7:0] angle;
  logic              ang_valid;
  logic              ang_ready;
  logic              wbdone;
  logic              busy;

  modport master (
    output angle,
    output ang_valid,
    output busy,
    input  ang_ready,
    input  wbdone
  );

  modport slave (
    input  angle,
    input  ang_valid,
    input  busy,
    output ang_ready,
    output wbdone
  );
endinterface

// File: rtl/angle_selector.sv
// Steering-angle entry block: debounces the up/down/go pushbuttons, keeps a
// clamped signed angle, and hands it to the weight block over a valid/ready
// request that completes on wbdone. Sweep mode ping-pongs the angle between
// the bounds after every completed weight computation.
module angle_selector #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP            = 5,
  parameter int ANG_MAX         = 90,
  parameter int ANG_MIN         = -90
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_up_n,
  input  logic              key_dn_n,
  input  logic              key_go_n,
  input  logic              sweep_en,
  angle_selector_if.master  bus
);

  // Counter only has to hold DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Angle arithmetic is one bit wider so that a step past a bound is
  // visible before clamping/reflecting.
  localparam logic signed [8:0] STEP9 = 9'(STEP);
  localparam logic signed [8:0] MAX9  = 9'(ANG_MAX);
  localparam logic signed [8:0] MIN9  = 9'(ANG_MIN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Bit 0 = up, bit 1 = down, bit 2 = go.
  logic [2:0] keys_n;
  logic [2:0] press;
  logic       up_press;
  logic       dn_press;
  logic       go_press;

  assign keys_n = {key_go_n, key_dn_n, key_up_n};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      logic          sync1_reg;
      logic          sync2_reg;
      logic          stable_reg;
      logic          press_reg;
      logic [CW-1:0] cnt_reg;

      // Bring the asynchronous key level into the clock domain.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
        end else begin
          sync1_reg <= keys_n[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES
      // samples in a row; emit a one-cycle pulse on the press (1->0) flip.
      always_ff @(posedge clk) begin
        if (reset) begin
          stable_reg <= 1'b1;
          cnt_reg    <= '0;
          press_reg  <= 1'b0;
        end else if (sync2_reg != stable_reg) begin
          if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
            press_reg  <= stable_reg;
          end else begin
            cnt_reg    <= cnt_reg + CW'(1);
            press_reg  <= 1'b0;
          end
        end else begin
          cnt_reg   <= '0;
          press_reg <= 1'b0;
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  assign up_press = press[0];
  assign dn_press = press[1];
  assign go_press = press[2];

  state_t            state_reg;
  state_t            state_next;
  logic signed [7:0] angle_reg;
  logic signed [7:0] angle_next;
  logic              dir_up_reg;
  logic              dir_up_next;
  logic              ang_valid_reg;
  logic              busy_reg;

  logic signed [8:0] ang_ext;
  logic signed [8:0] ang_inc;
  logic signed [8:0] ang_dec;
  logic signed [8:0] up_clamped;
  logic signed [8:0] dn_clamped;

  assign ang_ext    = {angle_reg[7], angle_reg};
  assign ang_inc    = ang_ext + STEP9;
  assign ang_dec    = ang_ext - STEP9;
  assign up_clamped = (ang_inc > MAX9) ? MAX9 : ang_inc;
  assign dn_clamped = (ang_dec < MIN9) ? MIN9 : ang_dec;

  // Next state, next angle and sweep direction.
  always_comb begin
    state_next  = state_reg;
    angle_next  = angle_reg;
    dir_up_next = dir_up_reg;
    case (state_reg)
      IDLE: begin
        // Launching a request wins over a manual step in the same cycle;
        // the manual step is dropped, not deferred.
        if (go_press || sweep_en) begin
          state_next = REQ;
        end else if (up_press && !dn_press) begin
          angle_next = up_clamped[7:0];
        end else if (dn_press && !up_press) begin
          angle_next = dn_clamped[7:0];
        end
      end
      REQ: begin
        // Angle is frozen here; completion pulses are not expected yet.
        if (bus.ang_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.wbdone) begin
          if (sweep_en) begin
            // Reflect off a bound: flip direction and step back instead.
            if (dir_up_reg) begin
              if (ang_inc > MAX9) begin
                dir_up_next = 1'b0;
                angle_next  = ang_dec[7:0];
              end else begin
                angle_next  = ang_inc[7:0];
              end
            end else begin
              if (ang_dec < MIN9) begin
                dir_up_next = 1'b1;
                angle_next  = ang_inc[7:0];
              end else begin
                angle_next  = ang_dec[7:0];
              end
            end
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, angle and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      angle_reg     <= '0;
      dir_up_reg    <= 1'b1;
      ang_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      angle_reg     <= angle_next;
      dir_up_reg    <= dir_up_next;
      ang_valid_reg <= (state_next == REQ);
      busy_reg      <= (state_next != IDLE);
    end
  end

  assign bus.angle     = angle_reg;
  assign bus.ang_valid = ang_valid_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_angle_selector.sv
// Bench for angle_selector: directed scenarios plus randomized key/handshake
// traffic, checked every cycle against a transaction-level model.
module tb_angle_selector;
  localparam int D    = 4;
  localparam int STEP = 5;
  localparam int AMAX = 90;
  localparam int AMIN = -90;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic key_up_n = 1'b1;
  logic key_dn_n = 1'b1;
  logic key_go_n = 1'b1;
  logic sweep_en = 1'b0;

  angle_selector_if bus();

  angle_selector #(
    .DEBOUNCE_CYCLES(D),
    .STEP(STEP),
    .ANG_MAX(AMAX),
    .ANG_MIN(AMIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_up_n(key_up_n),
    .key_dn_n(key_dn_n),
    .key_go_n(key_go_n),
    .sweep_en(sweep_en),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nprint = 0;

  // Model: phase 0 = idle, 1 = requesting, 2 = waiting for completion.
  int m_angle = 0;
  int m_phase = 0;
  int m_dir   = 1;
  int t_xfer  = -100;
  int resp_mode = 0;   // 0 manual, 1 random responder, 2 sweep responder
  bit chk_en = 1'b1;

  // Edge numbers at which a debounced press takes effect.
  bit ev_up[int];
  bit ev_dn[int];
  bit ev_go[int];

  // Angles actually transferred by the DUT and the edge of each transfer.
  int xa[$];
  int xt[$];

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply one clock edge worth of specification rules to the model.
  task automatic model_update();
    bit u, d, g;
    int c;
    u = ev_up.exists(cyc);
    d = ev_dn.exists(cyc);
    g = ev_go.exists(cyc);
    if (reset) begin
      m_angle = 0;
      m_phase = 0;
      m_dir   = 1;
    end else begin
      case (m_phase)
        0: begin
          if (g || sweep_en) m_phase = 1;
          else if (u && !d) m_angle = (m_angle + STEP > AMAX) ? AMAX : m_angle + STEP;
          else if (d && !u) m_angle = (m_angle - STEP < AMIN) ? AMIN : m_angle - STEP;
        end
        1: begin
          if (bus.ang_ready) begin
            m_phase = 2;
            t_xfer  = cyc;
          end
        end
        default: begin
          if (bus.wbdone) begin
            if (sweep_en) begin
              c = m_angle + m_dir * STEP;
              if (c > AMAX || c < AMIN) begin
                m_dir = -m_dir;
                c = m_angle + m_dir * STEP;
              end
              m_angle = c;
              m_phase = 1;
            end else begin
              m_phase = 0;
            end
          end
        end
      endcase
    end
  endtask

  // One clock cycle: responder inputs, edge, model, then settle past negedge.
  task automatic step();
    if (resp_mode == 1) begin
      bus.ang_ready = ($urandom % 2) == 1;
      bus.wbdone    = (m_phase == 2) ? (($urandom % 4) == 0) : (($urandom % 20) == 0);
    end else if (resp_mode == 2) begin
      bus.ang_ready = 1'b1;
      bus.wbdone    = (m_phase == 2) && (cyc + 1 == t_xfer + 4);
    end
    if (bus.ang_valid === 1'b1 && bus.ang_ready === 1'b1) begin
      xa.push_back(int'(bus.angle));
      xt.push_back(cyc + 1);
    end
    @(posedge clk);
    cyc++;
    model_update();
    @(negedge clk);
    #1;
  endtask

  // Hold the selected keys low for 'hold' cycles, then release for 'gap'.
  task automatic press(bit u, bit d, bit g, int hold, int gap);
    int f;
    f = cyc + 1;
    if (u) key_up_n = 1'b0;
    if (d) key_dn_n = 1'b0;
    if (g) key_go_n = 1'b0;
    if (hold >= D) begin
      if (u) ev_up[f + D + 2] = 1'b1;
      if (d) ev_dn[f + D + 2] = 1'b1;
      if (g) ev_go[f + D + 2] = 1'b1;
    end
    $display("txn cyc=%0d up=%0b dn=%0b go=%0b hold=%0d gap=%0d angle=%0d busy=%0b",
             cyc, u, d, g, hold, gap, int'(bus.angle), bus.busy);
    repeat (hold) step();
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    key_go_n = 1'b1;
    repeat (gap) step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    check("idle_timeout", (bus.busy === 1'b0) ? 0 : 1, 0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      total += 3;
      if (bus.angle !== 8'(m_angle)) begin
        bad++;
        if (nprint < 30) $display("FAIL angle cyc=%0d: dut=%0d model=%0d", cyc, int'(bus.angle), m_angle);
        nprint++;
      end
      if (bus.ang_valid !== (m_phase == 1)) begin
        bad++;
        if (nprint < 30) $display("FAIL ang_valid cyc=%0d: dut=%b model=%0b", cyc, bus.ang_valid, m_phase == 1);
        nprint++;
      end
      if (bus.busy !== (m_phase != 0)) begin
        bad++;
        if (nprint < 30) $display("FAIL busy cyc=%0d: dut=%b model=%0b", cyc, bus.busy, m_phase != 0);
        nprint++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, h, g;
    bus.ang_ready = 1'b0;
    bus.wbdone    = 1'b0;

    // Reset
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset_angle", int'(bus.angle), 0);
    check("reset_valid", int'(bus.ang_valid), 0);
    check("reset_busy", int'(bus.busy), 0);

    // Saturation at both bounds
    for (int i = 1; i <= 19; i++) begin
      press(1'b1, 1'b0, 1'b0, D + 2, D + 4);
      if (i == 17) check("up_17", int'(bus.angle), 85);
      if (i >= 18) check("up_sat", int'(bus.angle), 90);
    end
    for (int i = 1; i <= 37; i++) begin
      press(1'b0, 1'b1, 1'b0, D + 2, D + 4);
      if (i == 35) check("dn_35", int'(bus.angle), -85);
      if (i >= 36) check("dn_sat", int'(bus.angle), -90);
    end

    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset2_angle", int'(bus.angle), 0);

    // Bounce rejection
    press(1'b1, 1'b0, 1'b0, 3, D + 4);
    press(1'b1, 1'b0, 1'b0, 3, 1);
    press(1'b1, 1'b0, 1'b0, 1, 1);
    press(1'b1, 1'b0, 1'b0, 2, 1);
    press(1'b1, 1'b0, 1'b0, 3, D + 4);
    check("bounce_angle", int'(bus.angle), 0);

    // Debounce latency: first low sample at edge k+1, change at edge k+7
    key_up_n = 1'b0;
    ev_up[cyc + 1 + D + 2] = 1'b1;
    repeat (6) step();
    key_up_n = 1'b1;
    check("latency_before", int'(bus.angle), 0);
    step();
    check("latency_after", int'(bus.angle), 5);
    repeat (D + 4) step();

    press(1'b1, 1'b0, 1'b0, D + 2, D + 4);
    press(1'b1, 1'b0, 1'b0, D + 2, D + 4);
    check("angle_15", int'(bus.angle), 15);

    // Handshake with ready held low
    press(1'b0, 1'b0, 1'b1, D + 2, D + 4);
    check("hs_valid", int'(bus.ang_valid), 1);
    repeat (5) step();
    check("hs_hold_valid", int'(bus.ang_valid), 1);
    check("hs_hold_angle", int'(bus.angle), 15);
    bus.ang_ready = 1'b1;
    step();
    bus.ang_ready = 1'b0;
    check("hs_xfer_valid", int'(bus.ang_valid), 0);
    check("hs_xfer_busy", int'(bus.busy), 1);
    press(1'b1, 1'b0, 1'b0, D + 2, D + 4);
    check("hs_up_in_wait", int'(bus.angle), 15);
    bus.wbdone = 1'b1;
    step();
    bus.wbdone = 1'b0;
    check("hs_done_busy", int'(bus.busy), 0);
    check("hs_done_angle", int'(bus.angle), 15);

    // Simultaneous events
    press(1'b1, 1'b1, 1'b0, D + 2, D + 4);
    check("updn_same", int'(bus.angle), 15);
    press(1'b1, 1'b0, 1'b1, D + 2, D + 4);
    check("goup_valid", int'(bus.ang_valid), 1);
    check("goup_angle", int'(bus.angle), 15);
    bus.wbdone = 1'b1;
    step();
    bus.wbdone = 1'b0;
    check("wbdone_in_req", int'(bus.ang_valid), 1);
    bus.ang_ready = 1'b1;
    step();
    bus.ang_ready = 1'b0;
    bus.wbdone = 1'b1;
    step();
    bus.wbdone = 1'b0;
    check("goup_done", int'(bus.busy), 0);

    // Sweep from 85 with a bound reflection at 90
    repeat (14) press(1'b1, 1'b0, 1'b0, D + 2, D + 4);
    check("angle_85", int'(bus.angle), 85);
    xa.delete();
    xt.delete();
    sweep_en  = 1'b1;
    resp_mode = 2;
    r = 0;
    while (xa.size() < 4 && r < 100) begin
      step();
      r++;
    end
    sweep_en = 1'b0;
    check("sweep_count", xa.size(), 4);
    if (xa.size() >= 4) begin
      check("sweep_a0", xa[0], 85);
      check("sweep_a1", xa[1], 90);
      check("sweep_a2", xa[2], 85);
      check("sweep_a3", xa[3], 80);
      check("sweep_period", xt[2] - xt[1], 5);
    end
    wait_idle();
    resp_mode = 0;
    bus.ang_ready = 1'b0;
    bus.wbdone = 1'b0;
    repeat (2) step();

    // Reset while a request is outstanding
    press(1'b0, 1'b0, 1'b1, D + 2, D + 4);
    check("req_before_reset", int'(bus.ang_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_req_angle", int'(bus.angle), 0);
    check("rst_req_valid", int'(bus.ang_valid), 0);
    check("rst_req_busy", int'(bus.busy), 0);
    repeat (2) step();

    // Randomized traffic
    resp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      sweep_en = (($urandom % 6) == 0);
      r = $urandom % 8;
      h = D + ($urandom % 5);
      g = D + 4 + ($urandom % 3);
      case (r)
        0, 1: press(1'b1, 1'b0, 1'b0, h, g);
        2:    press(1'b0, 1'b1, 1'b0, h, g);
        3:    press(1'b0, 1'b0, 1'b1, h, g);
        4:    press(1'b1, 1'b1, 1'b0, h, g);
        5:    press(1'b1, 1'b0, 1'b1, h, g);
        6:    press(($urandom % 2) == 1, ($urandom % 2) == 1, ($urandom % 2) == 1,
                    1 + ($urandom % (D - 1)), 1 + ($urandom % 3));
        default: begin
          if (($urandom % 4) == 0) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            $display("txn cyc=%0d reset", cyc);
          end else begin
            repeat (1 + ($urandom % 6)) step();
          end
        end
      endcase
    end
    sweep_en = 1'b0;
    wait_idle();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
